// File: rtl/state_transition_sequencer_if.sv
// Request/status bundle between the host/scenario logic and the state transition sequencer.
interface state_transition_sequencer_if;
    logic        clk_en;
    logic        req_valid;
    logic [2:0]  req_state;
    logic [15:0] req_duration;
    logic        abort;
    logic        req_ready;
    logic [2:0]  state_select;
    logic        transitioning;
    logic [15:0] transition_progress;
    logic [15:0] transition_duration;
    logic [2:0]  state_transition_from;
    logic [2:0]  state_transition_to;
    logic        done;
    logic        aborted;
    logic        reject;

    modport master (
        output clk_en, req_valid, req_state, req_duration, abort,
        input  req_ready, state_select, transitioning, transition_progress,
               transition_duration, state_transition_from, state_transition_to,
               done, aborted, reject
    );

    modport slave (
        input  clk_en, req_valid, req_state, req_duration, abort,
        output req_ready, state_select, transitioning, transition_progress,
               transition_duration, state_transition_from, state_transition_to,
               done, aborted, reject
    );
endinterface

// File: rtl/state_transition_sequencer.sv
// Timed consciousness-state sequencer: accepts a target, walks the transition per tick,
// commits, then holds off new requests for a dwell window.
module state_transition_sequencer #(
    parameter int NUM_STATES   = 5,
    parameter int RESET_STATE  = 0,
    parameter int DWELL_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    state_transition_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, TRANSIT, DWELL} fsm_t;

    localparam logic [2:0]  RST_ST     = 3'(RESET_STATE);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam fsm_t        POST_COMMIT = (DWELL_CYCLES == 0) ? IDLE : DWELL;

    fsm_t        fsm_q, fsm_d;
    logic [2:0]  sel_q, sel_d, from_q, from_d, to_q, to_d;
    logic        trans_q, trans_d, done_q, done_d, abrt_q, abrt_d, rej_q, rej_d;
    logic [15:0] prog_q, prog_d, dur_q, dur_d, dwell_q, dwell_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            sel_q   <= RST_ST;
            from_q  <= RST_ST;
            to_q    <= RST_ST;
            trans_q <= 1'b0;
            prog_q  <= '0;
            dur_q   <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            sel_q   <= sel_d;
            from_q  <= from_d;
            to_q    <= to_d;
            trans_q <= trans_d;
            prog_q  <= prog_d;
            dur_q   <= dur_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        sel_d   = sel_q;
        from_d  = from_q;
        to_d    = to_q;
        trans_d = trans_q;
        prog_d  = prog_q;
        dur_d   = dur_q;
        dwell_d = dwell_q;
        // Pulses self-clear every clk edge, independent of clk_en
        done_d  = 1'b0;
        abrt_d  = 1'b0;
        rej_d   = 1'b0;
        if (bus.clk_en) begin
            unique case (fsm_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (int'(bus.req_state) >= NUM_STATES) begin
                            rej_d = 1'b1;
                        end else if (bus.req_state != sel_q) begin
                            from_d = sel_q;
                            to_d   = bus.req_state;
                            dur_d  = bus.req_duration;
                            if (bus.req_duration == 16'd0) begin
                                sel_d   = bus.req_state;
                                done_d  = 1'b1;
                                dwell_d = '0;
                                fsm_d   = POST_COMMIT;
                            end else begin
                                trans_d = 1'b1;
                                prog_d  = '0;
                                fsm_d   = TRANSIT;
                            end
                        end
                    end
                end
                TRANSIT: begin
                    if (bus.abort) begin
                        trans_d = 1'b0;
                        prog_d  = '0;
                        abrt_d  = 1'b1;
                        fsm_d   = IDLE;
                    end else if (prog_q == dur_q - 16'd1) begin
                        sel_d   = to_q;
                        trans_d = 1'b0;
                        prog_d  = '0;
                        done_d  = 1'b1;
                        dwell_d = '0;
                        fsm_d   = POST_COMMIT;
                    end else begin
                        prog_d = prog_q + 16'd1;
                    end
                end
                DWELL: begin
                    if (dwell_q == DWELL_LAST) fsm_d = IDLE;
                    else                       dwell_d = dwell_q + 16'd1;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready             = (fsm_q == IDLE);
        bus.state_select          = sel_q;
        bus.transitioning         = trans_q;
        bus.transition_progress   = prog_q;
        bus.transition_duration   = dur_q;
        bus.state_transition_from = from_q;
        bus.state_transition_to   = to_q;
        bus.done                  = done_q;
        bus.aborted               = abrt_q;
        bus.reject                = rej_q;
    end
endmodule

// File: tb/tb_state_transition_sequencer.sv
// Directed bench for state_transition_sequencer with hand-computed expectations.
module tb_state_transition_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n;
    logic saw_trans;

    state_transition_sequencer_if bus ();

    state_transition_sequencer #(
        .NUM_STATES(5), .RESET_STATE(0), .DWELL_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] st, input logic [15:0] dur);
        bus.req_valid    = 1'b1;
        bus.req_state    = st;
        bus.req_duration = dur;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    // Ticks until req_ready rises (bounded), recording whether transitioning ever rose
    task automatic wait_ready(output int cnt);
        cnt = 0;
        saw_trans = 1'b0;
        while (!bus.req_ready && cnt < 200) begin
            bus.req_valid    = (cnt == 10);
            bus.req_state    = 3'd1;
            bus.req_duration = 16'd9;
            bus.abort        = (cnt == 20);
            tick();
            if (bus.transitioning) saw_trans = 1'b1;
            cnt++;
        end
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
    endtask

    initial begin
        bus.clk_en = 1'b1; bus.req_valid = 1'b0; bus.req_state = '0;
        bus.req_duration = '0; bus.abort = 1'b0;
        #23;
        chk("rst_sel",   bus.state_select, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_trans", bus.transitioning, 0);
        chk("rst_pulse", {bus.done, bus.aborted, bus.reject}, 0);
        chk("rst_dur",   bus.transition_duration, 0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_sel",   bus.state_select, 0);
        chk("idle_ready", bus.req_ready, 1);
        chk("idle_pulse", {bus.done, bus.aborted, bus.reject}, 0);

        // 0 -> 4 over 5 ticks, with a stray request mid-transit
        req(3'd4, 16'd5);
        chk("t2_trans", bus.transitioning, 1);
        chk("t2_from",  bus.state_transition_from, 0);
        chk("t2_to",    bus.state_transition_to, 4);
        chk("t2_prog0", bus.transition_progress, 0);
        chk("t2_ready", bus.req_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) req(3'd1, 16'd9);
            else tick();
            chk($sformatf("t2_prog%0d", i), bus.transition_progress, i);
            chk("t2_sel_hold", bus.state_select, 0);
        end
        chk("t2_to_hold", bus.state_transition_to, 4);
        tick();
        chk("t2_commit_sel", bus.state_select, 4);
        chk("t2_commit_tr",  bus.transitioning, 0);
        chk("t2_done",       bus.done, 1);
        chk("t2_prog_clr",   bus.transition_progress, 0);
        wait_ready(n);
        chk("t2_dwell_len", n, 64);
        chk("t2_dwell_to",  bus.state_transition_to, 4);
        chk("t2_dwell_dur", bus.transition_duration, 5);
        chk("t2_dwell_sel", bus.state_select, 4);

        // Zero-duration request commits at once
        req(3'd2, 16'd0);
        chk("t3_sel",   bus.state_select, 2);
        chk("t3_done",  bus.done, 1);
        chk("t3_trans", bus.transitioning, 0);
        chk("t3_dur",   bus.transition_duration, 0);
        chk("t3_from",  bus.state_transition_from, 4);
        wait_ready(n);
        chk("t3_dwell_len", n, 64);
        chk("t3_no_trans",  saw_trans, 0);

        // Abort at progress 6
        req(3'd3, 16'd10);
        repeat (6) tick();
        chk("t4_prog6", bus.transition_progress, 6);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        chk("t4_aborted", bus.aborted, 1);
        chk("t4_done",    bus.done, 0);
        chk("t4_sel",     bus.state_select, 2);
        chk("t4_ready",   bus.req_ready, 1);
        chk("t4_to",      bus.state_transition_to, 3);
        chk("t4_dur",     bus.transition_duration, 10);
        chk("t4_prog",    bus.transition_progress, 0);
        tick();
        chk("t4_ab_clr",  bus.aborted, 0);

        // Same-state and invalid requests
        req(3'd2, 16'd7);
        chk("t5_same_pulse", {bus.done, bus.aborted, bus.reject}, 0);
        chk("t5_same_ready", bus.req_ready, 1);
        chk("t5_same_dur",   bus.transition_duration, 10);
        req(3'd6, 16'd7);
        chk("t5_reject", bus.reject, 1);
        chk("t5_rej_sel", bus.state_select, 2);
        chk("t5_rej_to",  bus.state_transition_to, 3);
        tick();
        chk("t5_rej_clr", bus.reject, 0);

        // clk_en low holds progress; abort on the final tick
        req(3'd1, 16'd3);
        bus.clk_en = 1'b0; tick(); tick();
        chk("ce_hold_prog", bus.transition_progress, 0);
        chk("ce_hold_tr",   bus.transitioning, 1);
        bus.clk_en = 1'b1;
        tick(); tick();
        chk("t6_prog_last", bus.transition_progress, 2);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        chk("t6_aborted", bus.aborted, 1);
        chk("t6_nodone",  bus.done, 0);
        chk("t6_sel",     bus.state_select, 2);
        bus.clk_en = 1'b0; tick();
        chk("t6_pulse_clr_ce0", bus.aborted, 0);
        bus.clk_en = 1'b1;

        // Reset mid-transit
        req(3'd4, 16'd5);
        tick();
        rst = 1'b1; #1;
        chk("mr_trans", bus.transitioning, 0);
        chk("mr_sel",   bus.state_select, 0);
        chk("mr_from",  bus.state_transition_from, 0);
        chk("mr_to",    bus.state_transition_to, 0);
        chk("mr_prog",  bus.transition_progress, 0);
        tick();
        chk("mr_pulse", {bus.done, bus.aborted, bus.reject}, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
